// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rx.sv
// Tri-state bus receiver: samples Z while EN is high into a small capture FIFO,
// keeps the last driven bus value, and flags words lost to a full FIFO.
module gf180mcu_fd_sc_mcu9t5v0__bufz_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic                     EN,
    input  logic [WIDTH-1:0]         Z,
    output logic [WIDTH-1:0]         Q,
    output logic                     Q_VALID,
    input  logic                     Q_READY,
    output logic [WIDTH-1:0]         KEEP,
    output logic [$clog2(DEPTH):0]   FILL,
    output logic                     OVF,
    input  logic                     CLR_OVF,
    inout  wire                      VDD,
    inout  wire                      VSS
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q,   fill_d;
    logic [WIDTH-1:0] keep_q,   keep_d;
    logic             ovf_q,    ovf_d;

    logic full;
    logic push;
    logic pop;

    // Supply pins are carried for library consistency only.
    wire unused_supply = &{1'b0, VDD, VSS};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        keep_d   = keep_q;
        ovf_d    = ovf_q;

        full = (fill_q == FW'(DEPTH));
        pop  = (fill_q != '0) && Q_READY;
        push = EN && (!full || pop);

        if (EN) begin
            keep_d = Z;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + FW'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FW'(1);
        end

        // A fresh overflow beats a simultaneous clear.
        if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (EN && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            keep_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            keep_q   <= keep_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is not reset; Q is masked by Q_VALID so stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= Z;
        end
    end

    assign Q_VALID = (fill_q != '0);
    assign Q       = Q_VALID ? mem[rd_ptr_q] : '0;
    assign KEEP    = keep_q;
    assign FILL    = fill_q;
    assign OVF     = ovf_q;

endmodule
